// File: rtl/upsampling_layer.sv
// Nearest-neighbour upsampler: repeats each pixel SCALE times across and each row SCALE times down.
// Latency 1 cycle from input accept to out_data; backpressure stalls all state, in_ready drops while repeating.
module upsampling_layer #(
    parameter int I_WIDTH    = 8,
    parameter int CHANNELS   = 1,
    parameter int IMAGE_SIZE = 4,
    parameter int SCALE      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_en,
    input  logic [I_WIDTH*CHANNELS-1:0]  in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [I_WIDTH*CHANNELS-1:0]  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last
);

    localparam int DW = I_WIDTH * CHANNELS;
    localparam int CW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMAGE_SIZE - 1);
    localparam logic [SW-1:0] REP_MAX = SW'(SCALE - 1);

    typedef enum logic {S_PASS, S_REPLAY} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d, row_q, row_d;
    logic [SW-1:0]   hrep_q, hrep_d, vrep_q, vrep_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [DW-1:0]   hold_q, hold_d;
    logic [DW-1:0]   line_q [IMAGE_SIZE];

    logic            slot;
    logic            in_ready_c;
    logic            in_fire;
    logic            load;
    logic [DW-1:0]   src;

    always_comb begin
        slot       = clk_en && (!out_valid_q || out_ready);
        in_ready_c = slot && (state_q == S_PASS) && (hrep_q == '0);
        in_fire    = in_valid && in_ready_c;

        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        hrep_d      = hrep_q;
        vrep_d      = vrep_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        hold_d      = hold_q;
        load        = 1'b0;
        src         = hold_q;

        // First copy of a pixel comes straight from the input; later copies from hold or the row buffer.
        if (state_q == S_PASS) begin
            if (hrep_q == '0) begin
                load = in_fire;
                src  = in_data;
            end else begin
                load = slot;
                src  = hold_q;
            end
        end else begin
            load = slot;
            src  = line_q[col_q];
        end

        if (in_fire) begin
            hold_d = in_data;
        end

        if (load) begin
            out_data_d  = src;
            out_valid_d = 1'b1;
            out_last_d  = (row_q == COL_MAX) && (vrep_q == REP_MAX) &&
                          (col_q == COL_MAX) && (hrep_q == REP_MAX);
            if (hrep_q == REP_MAX) begin
                hrep_d = '0;
                if (col_q == COL_MAX) begin
                    col_d = '0;
                    if (vrep_q == REP_MAX) begin
                        vrep_d = '0;
                        row_d  = (row_q == COL_MAX) ? '0 : row_q + CW'(1);
                    end else begin
                        vrep_d = vrep_q + SW'(1);
                    end
                end else begin
                    col_d = col_q + CW'(1);
                end
            end else begin
                hrep_d = hrep_q + SW'(1);
            end
        end else if (slot) begin
            out_valid_d = 1'b0;
        end

        state_d = (vrep_d == '0) ? S_PASS : S_REPLAY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_PASS;
            col_q       <= '0;
            row_q       <= '0;
            hrep_q      <= '0;
            vrep_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            hrep_q      <= hrep_d;
            vrep_q      <= vrep_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            hold_q      <= hold_d;
        end
    end

    // Row buffer holds the current input row for the vertical repeats; contents need no reset.
    always_ff @(posedge clk) begin
        if (!rst && in_fire) begin
            line_q[col_q] <= in_data;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_upsampling_layer.sv
// Directed bench for upsampling_layer: three configurations checked against hand-derived sequences.
module tb_upsampling_layer;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;

    // A: IMAGE_SIZE=2, SCALE=2, 1 channel
    logic [7:0]  a_in_data, a_out_data;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    // B: IMAGE_SIZE=3, SCALE=1, 2 channels
    logic [15:0] b_in_data, b_out_data;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    // C: IMAGE_SIZE=1, SCALE=3, 1 channel
    logic [7:0]  c_in_data, c_out_data;
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    upsampling_layer #(.I_WIDTH(8), .CHANNELS(1), .IMAGE_SIZE(2), .SCALE(2)) dut_a (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_last(a_out_last)
    );

    upsampling_layer #(.I_WIDTH(8), .CHANNELS(2), .IMAGE_SIZE(3), .SCALE(1)) dut_b (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_last(b_out_last)
    );

    upsampling_layer #(.I_WIDTH(8), .CHANNELS(1), .IMAGE_SIZE(1), .SCALE(3)) dut_c (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_last(c_out_last)
    );

    task automatic test_reset();
        rst = 1'b1; clk_en = 1'b1;
        a_in_valid = 0; b_in_valid = 0; c_in_valid = 0;
        a_in_data = '0; b_in_data = '0; c_in_data = '0;
        a_out_ready = 1; b_out_ready = 1; c_out_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors += 8;
        if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset a_out_valid: got %b want 0", a_out_valid); end
        if (a_out_last !== 1'b0) begin miscompares++; $display("FAIL reset a_out_last: got %b want 0", a_out_last); end
        if (a_out_data !== 8'h00) begin miscompares++; $display("FAIL reset a_out_data: got %h want 00", a_out_data); end
        if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset a_in_ready: got %b want 1", a_in_ready); end
        if (b_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset b_out_valid: got %b want 0", b_out_valid); end
        if (b_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset b_in_ready: got %b want 1", b_in_ready); end
        if (c_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset c_out_valid: got %b want 0", c_out_valid); end
        if (c_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset c_in_ready: got %b want 1", c_in_ready); end
        @(posedge clk); #1;
    endtask

    // Drives one 2x2 frame into A and checks the 4x4 result; optional ready toggling,
    // a 3-cycle clk_en drop after stall_at outputs, or a reset after abort_at outputs.
    task automatic run_frame_a(input logic [7:0] v0, input logic [7:0] v1,
                               input logic [7:0] v2, input logic [7:0] v3,
                               input bit toggle, input int stall_at, input int abort_at,
                               input string tag);
        logic [7:0] vals [4];
        logic [7:0] expv;
        int  ip = 0, optr = 0, cyc = 0, nl;
        bit  started = 0, stalled = 0, exp_rdy;
        vals = '{v0, v1, v2, v3};
        while (optr < 16 && cyc < 300) begin
            if (abort_at >= 0 && optr == abort_at) begin
                rst = 1'b1; a_in_valid = 0; a_out_ready = 1;
                @(posedge clk); #1 rst = 1'b0;
                @(negedge clk);
                vectors += 3;
                if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL %s post-reset out_valid: got %b want 0", tag, a_out_valid); end
                if (a_out_last !== 1'b0) begin miscompares++; $display("FAIL %s post-reset out_last: got %b want 0", tag, a_out_last); end
                if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL %s post-reset in_ready: got %b want 1", tag, a_in_ready); end
                @(posedge clk); #1;
                return;
            end
            if (stall_at >= 0 && optr == stall_at && !stalled) begin
                stalled = 1; clk_en = 1'b0; a_out_ready = 1;
                expv = vals[(optr / 8) * 2 + (optr / 2) % 2];
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    vectors += 3;
                    if (a_in_ready !== 1'b0) begin miscompares++; $display("FAIL %s frozen in_ready: got %b want 0", tag, a_in_ready); end
                    if (a_out_valid !== 1'b1) begin miscompares++; $display("FAIL %s frozen out_valid: got %b want 1", tag, a_out_valid); end
                    if (a_out_data !== expv) begin miscompares++; $display("FAIL %s frozen out_data: got %0d want %0d", tag, a_out_data, expv); end
                    @(posedge clk); #1;
                end
                clk_en = 1'b1;
            end
            a_in_valid  = (ip < 4);
            a_in_data   = (ip < 4) ? vals[ip] : 8'h00;
            a_out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            @(negedge clk);
            nl = optr + int'(a_out_valid);
            exp_rdy = (!a_out_valid || a_out_ready) && (nl % 2 == 0) && ((nl / 4) % 2 == 0);
            vectors++;
            if (a_in_ready !== exp_rdy) begin miscompares++; $display("FAIL %s in_ready at out %0d: got %b want %b", tag, optr, a_in_ready, exp_rdy); end
            if (a_out_valid) begin
                expv = vals[(optr / 8) * 2 + (optr / 2) % 2];
                vectors += 2;
                if (a_out_data !== expv) begin miscompares++; $display("FAIL %s out_data[%0d]: got %0d want %0d", tag, optr, a_out_data, expv); end
                if (a_out_last !== (optr == 15)) begin miscompares++; $display("FAIL %s out_last[%0d]: got %b want %b", tag, optr, a_out_last, optr == 15); end
            end else if (started && !toggle) begin
                vectors++; miscompares++;
                $display("FAIL %s bubble before out %0d: got out_valid 0 want 1", tag, optr);
            end
            if (a_in_valid && a_in_ready) begin ip++; started = 1; end
            if (a_out_valid && a_out_ready) optr++;
            cyc++;
            @(posedge clk); #1;
        end
        a_in_valid = 0;
        if (optr < 16) begin
            vectors++; miscompares++;
            $display("FAIL %s timeout: got %0d outputs want 16", tag, optr);
        end
    endtask

    task automatic test_basic();
        run_frame_a(8'd1, 8'd2, 8'd3, 8'd4, 1'b0, -1, -1, "basic");
    endtask

    task automatic test_backpressure();
        run_frame_a(8'd1, 8'd2, 8'd3, 8'd4, 1'b1, -1, -1, "backpressure");
    endtask

    task automatic test_clk_en();
        run_frame_a(8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 2, -1, "clk_en");
    endtask

    task automatic test_reset_mid();
        run_frame_a(8'd1, 8'd2, 8'd3, 8'd4, 1'b0, -1, 5, "reset_mid");
        run_frame_a(8'd5, 8'd6, 8'd7, 8'd8, 1'b0, -1, -1, "after_reset");
    endtask

    task automatic test_scale1();
        logic [15:0] expv;
        b_out_ready = 1;
        for (int n = 0; n <= 9; n++) begin
            b_in_valid = (n < 9);
            b_in_data  = (n < 9) ? {8'(n), 8'(100 + n)} : 16'h0000;
            @(negedge clk);
            if (n < 9) begin
                vectors++;
                if (b_in_ready !== 1'b1) begin miscompares++; $display("FAIL scale1 in_ready[%0d]: got %b want 1", n, b_in_ready); end
            end
            if (n > 0) begin
                expv = {8'(n - 1), 8'(99 + n)};
                vectors += 3;
                if (b_out_valid !== 1'b1) begin miscompares++; $display("FAIL scale1 out_valid[%0d]: got %b want 1", n - 1, b_out_valid); end
                if (b_out_data !== expv) begin miscompares++; $display("FAIL scale1 out_data[%0d]: got %h want %h", n - 1, b_out_data, expv); end
                if (b_out_last !== (n == 9)) begin miscompares++; $display("FAIL scale1 out_last[%0d]: got %b want %b", n - 1, b_out_last, n == 9); end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        vectors++;
        if (b_out_valid !== 1'b0) begin miscompares++; $display("FAIL scale1 idle out_valid: got %b want 0", b_out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_scale3();
        logic [7:0] expv;
        int  ip = 0, optr = 0, cyc = 0, nl;
        bit  started = 0, exp_rdy;
        c_out_ready = 1;
        while (optr < 18 && cyc < 100) begin
            c_in_valid = (ip < 2);
            c_in_data  = (ip == 0) ? 8'hAB : 8'hCD;
            @(negedge clk);
            nl = optr + int'(c_out_valid);
            exp_rdy = (nl % 9 == 0);
            vectors++;
            if (c_in_ready !== exp_rdy) begin miscompares++; $display("FAIL scale3 in_ready at out %0d: got %b want %b", optr, c_in_ready, exp_rdy); end
            if (c_out_valid) begin
                expv = (optr < 9) ? 8'hAB : 8'hCD;
                vectors += 2;
                if (c_out_data !== expv) begin miscompares++; $display("FAIL scale3 out_data[%0d]: got %h want %h", optr, c_out_data, expv); end
                if (c_out_last !== (optr % 9 == 8)) begin miscompares++; $display("FAIL scale3 out_last[%0d]: got %b want %b", optr, c_out_last, optr % 9 == 8); end
            end else if (started) begin
                vectors++; miscompares++;
                $display("FAIL scale3 bubble before out %0d: got out_valid 0 want 1", optr);
            end
            if (c_in_valid && c_in_ready) begin ip++; started = 1; end
            if (c_out_valid && c_out_ready) optr++;
            cyc++;
            @(posedge clk); #1;
        end
        c_in_valid = 0;
        if (optr < 18) begin
            vectors++; miscompares++;
            $display("FAIL scale3 timeout: got %0d outputs want 18", optr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_clk_en();
        test_reset_mid();
        test_scale1();
        test_scale3();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/upsampling_layer.md
Name: upsampling_layer

Overview:
- Nearest-neighbour upsampling (unpooling) layer; the inverse of the max pooling layer.
- Takes a raster-order stream of a square IMAGE_SIZE x IMAGE_SIZE multi-channel feature map and emits an (IMAGE_SIZE*SCALE) x (IMAGE_SIZE*SCALE) stream.
- Each pixel is repeated SCALE times horizontally; each row is repeated SCALE times vertically.
- A single-row buffer per channel supplies the vertical repeats.
- Sits between a pooled feature map and a following decoder/convolution layer. Valid/ready handshakes on both sides absorb the output-rate expansion.

Parameters:
- I_WIDTH, 8: bits per channel value.
- CHANNELS, 1: channels per pixel. All channels share one control path.
- IMAGE_SIZE, 4: input image width and height in pixels. Must be ≥1.
- SCALE, 2: upsampling factor. Must be ≥1.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- clk_en  input  1  global enable. When low, all state is frozen.
- in_data  input  I_WIDTH*CHANNELS  input pixel; channel i occupies bits [I_WIDTH*i +: I_WIDTH].
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle (combinational).
- out_data  output  I_WIDTH*CHANNELS  output pixel (registered).
- out_valid  output  1  out_data is valid (registered).
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  high with the final output pixel of a frame (registered).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: out_data=0, out_valid=0, out_last=0, state=S_PASS, all counters=0. Row buffer contents are not reset.
- Reset mid-frame discards the partial frame. The next accepted pixel is treated as pixel (0,0).
- Output slot free (slot) = clk_en && (!out_valid || out_ready).
- Transfers: an output transfer occurs when out_valid && out_ready && clk_en. An input transfer occurs when in_valid && in_ready.
- If slot is true and nothing new is loaded, out_valid clears to 0.
- Counters:
  - col: 0..IMAGE_SIZE-1.
  - hrep: 0..SCALE-1, horizontal repeat index.
  - vrep: 0..SCALE-1, vertical repeat index.
  - row: 0..IMAGE_SIZE-1, input row.
- hrep advancement: on every output load, hrep increments. On wrap from SCALE-1 to 0, col increments.
- col wrap: on wrap from IMAGE_SIZE-1 to 0, vrep increments. On vrep wrap, row increments. On row wrap, the frame is complete and the block is ready for the next frame immediately.
- S_PASS (vrep==0): in_ready = slot && hrep==0.
  - On input transfer: buf[col]<=in_data; hold<=in_data; out_data<=in_data; out_valid<=1.
  - While hrep!=0: each slot cycle loads out_data<=hold and out_valid<=1. No input is accepted.
- S_PASS exit: when the last repeat of col IMAGE_SIZE-1 loads, go to S_REPLAY if SCALE>1; otherwise remain in S_PASS for the next row.
- S_REPLAY (vrep 1..SCALE-1): in_ready=0. Each slot cycle loads out_data<=buf[col] and out_valid<=1. The buffer is read asynchronously. After the last load of vrep==SCALE-1, return to S_PASS.
- out_last: set to 1 on the load of the pixel where row, vrep, col and hrep are all at their maxima; otherwise 0 on each load. Held with out_data while stalled.
- Latency: an input accepted in cycle t appears on out_data/out_valid in cycle t+1.
- Throughput: with out_ready=1 and clk_en=1, one output per cycle with no bubbles, including S_PASS↔S_REPLAY transitions. Input is accepted at 1/SCALE rate during S_PASS.
- Stall: with out_valid=1 and out_ready=0, out_data, out_valid, out_last, counters and state hold. in_ready=0.
- clk_en low: nothing changes and in_ready=0. out_valid/out_data remain as registered.
- SCALE=1: pure registered pass-through, in_ready = slot.
- IMAGE_SIZE=1: the buffer has one entry and col is always 0.
- Counters use ceil(log2) widths with a minimum of 1 bit. Wrap comparisons are against parameter-1, never against power-of-two overflow.

Test Plan:
- Basic expansion (IMAGE_SIZE=2, SCALE=2, I_WIDTH=8, CHANNELS=1, out_ready=1):
  - Stimulus: inputs 1,2,3,4 presented back-to-back with in_valid=1.
  - Required: outputs 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4 on 16 consecutive cycles starting one cycle after the first accept.
  - Required: out_last high only on the 16th; in_ready low during hrep!=0 and S_REPLAY.
- Backpressure (same config): out_ready toggles 1,0,1,0… with the same inputs.
  - Required: identical output sequence, each value held stable while out_ready=0, no drops or duplicates.
- clk_en gating: drop clk_en for 3 cycles mid-row (after output 2 of row 0).
  - Required: all outputs and in_ready frozen; the sequence resumes exactly where it stopped.
- Reset mid-frame: assert rst after 5 outputs.
  - Required: next cycle out_valid=0, out_last=0, in_ready=1.
  - Then send 5,6,7,8. Required: output 5,5,6,6,5,5,6,6,7,7,8,8,7,7,8,8.
- SCALE=1, IMAGE_SIZE=3, CHANNELS=2: send 9 pixels {ch1,ch0} = {n, 100+n} for n=0..8.
  - Required: same 9 pixels out with 1-cycle latency, out_last on the 9th.
- SCALE=3, IMAGE_SIZE=1: input 0xAB.
  - Required: nine outputs of 0xAB, out_last on the 9th.
  - A second frame of input 0xCD follows without gaps.
